// File: rtl/spi_move_dispatcher_if.sv
// rtl/spi_move_dispatcher_if.sv - move FIFO head handshake towards the DDA timer
// Signals:
//   move_valid               FIFO head holds a committed move
//   move_ready               DDA accepts the head this cycle
//   move_duration            head duration
//   move_increment           head per-axis increment, axis k at [64k+63:64k]
//   move_incrementincrement  head per-axis increment delta, same packing
//   move_dir                 head direction bits
// master: dispatcher side, slave: DDA side.
interface spi_move_dispatcher_if #(
    parameter int NUM_AXES = 2
);
    logic                       move_valid;
    logic                       move_ready;
    logic [63:0]                move_duration;
    logic [64*NUM_AXES-1:0]     move_increment;
    logic [64*NUM_AXES-1:0]     move_incrementincrement;
    logic [NUM_AXES-1:0]        move_dir;

    modport master (
        output move_valid, move_duration, move_increment,
               move_incrementincrement, move_dir,
        input  move_ready
    );

    modport slave (
        input  move_valid, move_duration, move_increment,
               move_incrementincrement, move_dir,
        output move_ready
    );
endinterface

// File: rtl/spi_move_dispatcher.sv
// rtl/spi_move_dispatcher.sv - SPI word decoder, move staging and move FIFO
// Ports:
//   CLK, reset       clock, synchronous active-high reset
//   word_valid/data  one-cycle pulse with a received 64-bit word
//   word_send_data   word shifted out during the next SPI word
//   encoder_count    live encoder counts, axis k at [64k+63:64k]
//   mv               move FIFO head handshake (master modport)
//   enable           per-axis driver enable
//   clock_divisor    DDA tick divisor
//   buffer_dtr       FIFO not full
//   fill_count       FIFO entries held
//   overflow_err     sticky: a move was dropped on a full FIFO
//   header_err       sticky: unknown header received
module spi_move_dispatcher #(
    parameter int          NUM_AXES     = 2,
    parameter int          BUFFER_DEPTH = 4,
    parameter logic [23:0] VERSION      = 24'h000100
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          word_valid,
    input  logic [63:0]                   word_data,
    output logic [63:0]                   word_send_data,
    input  logic [64*NUM_AXES-1:0]        encoder_count,
    spi_move_dispatcher_if.master         mv,
    output logic [NUM_AXES-1:0]           enable,
    output logic [7:0]                    clock_divisor,
    output logic                          buffer_dtr,
    output logic [$clog2(BUFFER_DEPTH):0] fill_count,
    output logic                          overflow_err,
    output logic                          header_err
);
    localparam int AW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_DURATION, S_INC, S_INCINC, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         axis_q, axis_d;
    logic [NUM_AXES-1:0]   dir_stage_q, dir_stage_d;
    logic [63:0]           dur_stage_q, dur_stage_d;
    logic [63:0]           inc_stage_q [NUM_AXES];
    logic [63:0]           inc_stage_d [NUM_AXES];
    logic [63:0]           incinc_stage_q [NUM_AXES];
    logic [63:0]           incinc_stage_d [NUM_AXES];
    logic [63:0]           snap_q [NUM_AXES];
    logic [63:0]           snap_d [NUM_AXES];
    logic [63:0]           word_send_q, word_send_d;
    logic [NUM_AXES-1:0]   enable_q, enable_d;
    logic [7:0]            div_q, div_d;
    logic                  ovf_q, ovf_d;
    logic                  herr_q, herr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

    logic [NUM_AXES-1:0]   dir_mem    [BUFFER_DEPTH];
    logic [63:0]           dur_mem    [BUFFER_DEPTH];
    logic [64*NUM_AXES-1:0] inc_mem    [BUFFER_DEPTH];
    logic [64*NUM_AXES-1:0] incinc_mem [BUFFER_DEPTH];

    logic                   commit, push, pop, full;
    logic [64*NUM_AXES-1:0] inc_pack, incinc_pack;

    assign full = (count_q == CW'(BUFFER_DEPTH));
    assign pop  = mv.move_valid && mv.move_ready;

    always_comb begin
        state_d        = state_q;
        axis_d         = axis_q;
        dir_stage_d    = dir_stage_q;
        dur_stage_d    = dur_stage_q;
        inc_stage_d    = inc_stage_q;
        incinc_stage_d = incinc_stage_q;
        snap_d         = snap_q;
        word_send_d    = word_send_q;
        enable_d       = enable_q;
        div_d          = div_q;
        ovf_d          = ovf_q;
        herr_d         = herr_q;
        commit         = 1'b0;
        if (word_valid) begin
            case (state_q)
                S_IDLE: begin
                    word_send_d = '0;
                    case (word_data[63:56])
                        8'h01: begin
                            dir_stage_d = word_data[NUM_AXES-1:0];
                            for (int a = 0; a < NUM_AXES; a++)
                                snap_d[a] = encoder_count[64*a +: 64];
                            word_send_d = encoder_count[63:0];
                            axis_d      = '0;
                            state_d     = S_DURATION;
                        end
                        8'h0A: enable_d = word_data[NUM_AXES-1:0];
                        8'h0B: div_d    = word_data[7:0];
                        8'h0D: begin
                            ovf_d  = 1'b0;
                            herr_d = 1'b0;
                        end
                        8'h0C: begin
                            word_send_d = {ovf_q, herr_q, 46'd0, 16'(count_q)};
                            state_d     = S_DRAIN;
                        end
                        8'hFE: begin
                            word_send_d = {40'd0, VERSION};
                            state_d     = S_DRAIN;
                        end
                        default: herr_d = 1'b1;
                    endcase
                end
                S_DURATION: begin
                    dur_stage_d = word_data;
                    word_send_d = '0;
                    for (int a = 0; a < NUM_AXES; a++)
                        if (a == 1) word_send_d = snap_q[a];
                    axis_d  = '0;
                    state_d = S_INC;
                end
                S_INC: begin
                    inc_stage_d[axis_q] = word_data;
                    state_d             = S_INCINC;
                end
                S_INCINC: begin
                    incinc_stage_d[axis_q] = word_data;
                    if (int'(axis_q) < NUM_AXES - 1) begin
                        // Snapshot two axes ahead goes out while the next axis streams in.
                        word_send_d = '0;
                        for (int a = 0; a < NUM_AXES; a++)
                            if (a == int'(axis_q) + 2) word_send_d = snap_q[a];
                        axis_d  = axis_q + 1'b1;
                        state_d = S_INC;
                    end else begin
                        commit  = 1'b1;
                        axis_d  = '0;
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        // A full FIFO still accepts the move when its head leaves in the same cycle.
        push = commit && (!full || pop);
        if (commit && !push) ovf_d = 1'b1;
    end

    // The last incinc word is written straight from the bus so the move commits whole.
    always_comb begin
        inc_pack    = '0;
        incinc_pack = '0;
        for (int a = 0; a < NUM_AXES; a++) begin
            inc_pack[64*a +: 64]    = inc_stage_q[a];
            incinc_pack[64*a +: 64] = (a == NUM_AXES - 1) ? word_data : incinc_stage_q[a];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            axis_q      <= '0;
            dir_stage_q <= '0;
            dur_stage_q <= '0;
            for (int a = 0; a < NUM_AXES; a++) begin
                inc_stage_q[a]    <= '0;
                incinc_stage_q[a] <= '0;
                snap_q[a]         <= '0;
            end
            word_send_q <= '0;
            enable_q    <= '0;
            div_q       <= 8'd40;
            ovf_q       <= 1'b0;
            herr_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q        <= state_d;
            axis_q         <= axis_d;
            dir_stage_q    <= dir_stage_d;
            dur_stage_q    <= dur_stage_d;
            inc_stage_q    <= inc_stage_d;
            incinc_stage_q <= incinc_stage_d;
            snap_q         <= snap_d;
            word_send_q    <= word_send_d;
            enable_q       <= enable_d;
            div_q          <= div_d;
            ovf_q          <= ovf_d;
            herr_q         <= herr_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !reset) begin
            dir_mem[wr_ptr_q]    <= dir_stage_q;
            dur_mem[wr_ptr_q]    <= dur_stage_q;
            inc_mem[wr_ptr_q]    <= inc_pack;
            incinc_mem[wr_ptr_q] <= incinc_pack;
        end
    end

    assign mv.move_valid              = (count_q != '0);
    assign mv.move_dir                = dir_mem[rd_ptr_q];
    assign mv.move_duration           = dur_mem[rd_ptr_q];
    assign mv.move_increment          = inc_mem[rd_ptr_q];
    assign mv.move_incrementincrement = incinc_mem[rd_ptr_q];

    assign word_send_data = word_send_q;
    assign enable         = enable_q;
    assign clock_divisor  = div_q;
    assign buffer_dtr     = !full;
    assign fill_count     = count_q;
    assign overflow_err   = ovf_q;
    assign header_err     = herr_q;
endmodule

// File: tb/tb_spi_move_dispatcher.sv
// tb/tb_spi_move_dispatcher.sv - scoreboard bench for spi_move_dispatcher
module tb_spi_move_dispatcher;
    localparam int NA    = 2;
    localparam int DEPTH = 4;

    logic               CLK = 1'b0;
    logic               reset;
    logic               word_valid;
    logic [63:0]        word_data;
    logic [63:0]        word_send_data;
    logic [64*NA-1:0]   encoder_count;
    logic [NA-1:0]      enable;
    logic [7:0]         clock_divisor;
    logic               buffer_dtr;
    logic [2:0]         fill_count;
    logic               overflow_err;
    logic               header_err;

    spi_move_dispatcher_if #(.NUM_AXES(NA)) mv ();

    spi_move_dispatcher #(.NUM_AXES(NA), .BUFFER_DEPTH(DEPTH), .VERSION(24'h000100)) dut (
        .CLK(CLK), .reset(reset), .word_valid(word_valid), .word_data(word_data),
        .word_send_data(word_send_data), .encoder_count(encoder_count), .mv(mv),
        .enable(enable), .clock_divisor(clock_divisor), .buffer_dtr(buffer_dtr),
        .fill_count(fill_count), .overflow_err(overflow_err), .header_err(header_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NA-1:0]    dir;
        logic [63:0]      dur;
        logic [64*NA-1:0] inc;
        logic [64*NA-1:0] incinc;
    } move_t;

    move_t sb[$];
    int    total = 0;
    int    bad   = 0;
    logic  exp_ovf = 1'b0;

    localparam logic [63:0] ENC0 = 64'hA0A0_0000_1234_0001;
    localparam logic [63:0] ENC1 = 64'hB1B1_0000_5678_0002;

    task automatic send_word(input logic [63:0] d);
        word_valid = 1'b1;
        word_data  = d;
        @(posedge CLK); #1;
        word_valid = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic pop_one(input string tag);
        move_t m;
        total++;
        if (mv.move_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL %s_valid got=%b need=1 sb=%0d", tag, mv.move_valid, sb.size());
        end else begin
            m = sb.pop_front();
            total++;
            if (mv.move_duration !== m.dur || mv.move_dir !== m.dir ||
                mv.move_increment !== m.inc || mv.move_incrementincrement !== m.incinc) begin
                bad++;
                $display("FAIL %s_head got dur=%0d dir=%b inc=%h ii=%h need dur=%0d dir=%b inc=%h ii=%h",
                         tag, mv.move_duration, mv.move_dir, mv.move_increment,
                         mv.move_incrementincrement, m.dur, m.dir, m.inc, m.incinc);
            end
        end
        mv.move_ready = 1'b1;
        @(posedge CLK); #1;
        mv.move_ready = 1'b0;
    endtask

    task automatic send_move(input logic [NA-1:0] dir, input logic [63:0] dur,
                             input logic [63:0] i0, input logic [63:0] i1,
                             input logic [63:0] ii0, input logic [63:0] ii1,
                             input bit pop_on_commit);
        move_t m;
        logic [63:0] snap1;
        m.dir = dir; m.dur = dur; m.inc = {i1, i0}; m.incinc = {ii1, ii0};
        snap1 = encoder_count[127:64];
        send_word({8'h01, 54'd0, dir});
        total++;
        if (word_send_data !== encoder_count[63:0]) begin
            bad++;
            $display("FAIL snap0 got=%h need=%h", word_send_data, encoder_count[63:0]);
        end
        encoder_count = ~encoder_count;   // live change must not affect the snapshot
        send_word(dur);
        total++;
        if (word_send_data !== snap1) begin
            bad++;
            $display("FAIL snap1 got=%h need=%h", word_send_data, snap1);
        end
        encoder_count = ~encoder_count;
        send_word(i0);
        send_word(ii0);
        total++;
        if (word_send_data !== 64'd0) begin
            bad++;
            $display("FAIL snap_none got=%h need=0", word_send_data);
        end
        send_word(i1);
        if (pop_on_commit) begin
            move_t h;
            h = sb.pop_front();
            total++;
            if (mv.move_valid !== 1'b1 || mv.move_duration !== h.dur) begin
                bad++;
                $display("FAIL coincide_head got v=%b dur=%0d need v=1 dur=%0d",
                         mv.move_valid, mv.move_duration, h.dur);
            end
            mv.move_ready = 1'b1;
        end
        if (sb.size() < DEPTH) sb.push_back(m);
        else exp_ovf = 1'b1;
        word_valid = 1'b1;
        word_data  = ii1;
        @(posedge CLK); #1;
        word_valid    = 1'b0;
        mv.move_ready = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (overflow_err !== exp_ovf) begin
            bad++;
            $display("FAIL ovf_after_move got=%b need=%b", overflow_err, exp_ovf);
        end
        total++;
        if (fill_count !== 3'(sb.size())) begin
            bad++;
            $display("FAIL fill_after_move got=%0d need=%0d", fill_count, sb.size());
        end
    endtask

    task automatic test_reset();
        total++;
        if (mv.move_valid !== 1'b0 || fill_count !== 3'd0 || buffer_dtr !== 1'b1) begin
            bad++;
            $display("FAIL reset_fifo got v=%b fill=%0d dtr=%b need 0/0/1", mv.move_valid, fill_count, buffer_dtr);
        end
        total++;
        if (enable !== 2'b00 || clock_divisor !== 8'd40 || word_send_data !== 64'd0) begin
            bad++;
            $display("FAIL reset_cfg got en=%b div=%0d ws=%h need 0/40/0", enable, clock_divisor, word_send_data);
        end
        total++;
        if (overflow_err !== 1'b0 || header_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got o=%b h=%b need 0/0", overflow_err, header_err);
        end
    endtask

    task automatic test_version();
        send_word({8'hFE, 56'd0});
        total++;
        if (word_send_data !== 64'h0000_0000_0000_0100) begin
            bad++;
            $display("FAIL version got=%h need=100", word_send_data);
        end
        send_word({8'h0A, 54'd0, 2'b11});   // drained, must not act
        total++;
        if (enable !== 2'b00) begin
            bad++;
            $display("FAIL drain_ignored got en=%b need=00", enable);
        end
        send_word({8'h0B, 48'd0, 8'd7});
        total++;
        if (clock_divisor !== 8'd7 || word_send_data !== 64'd0) begin
            bad++;
            $display("FAIL divisor got div=%0d ws=%h need 7/0", clock_divisor, word_send_data);
        end
    endtask

    task automatic test_single_move();
        send_move(2'b10, 64'd1000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64'd0, 1'b0);
        total++;
        if (mv.move_increment[127:64] !== 64'hFFFF_FFFF_FFFF_FFFD || mv.move_dir !== 2'b10) begin
            bad++;
            $display("FAIL single_inc1 got inc1=%h dir=%b need -3/10", mv.move_increment[127:64], mv.move_dir);
        end
        pop_one("single");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            send_move(2'(i), 64'(100 + i), 64'(i), 64'(2*i), 64'(3*i), 64'(4*i), 1'b0);
        total++;
        if (fill_count !== 3'd4 || buffer_dtr !== 1'b0 || overflow_err !== 1'b1) begin
            bad++;
            $display("FAIL overflow got fill=%0d dtr=%b ovf=%b need 4/0/1", fill_count, buffer_dtr, overflow_err);
        end
        for (int i = 0; i < 4; i++) pop_one("ovf_pop");
        total++;
        if (mv.move_valid !== 1'b0 || fill_count !== 3'd0 || buffer_dtr !== 1'b1) begin
            bad++;
            $display("FAIL ovf_empty got v=%b fill=%0d dtr=%b need 0/0/1", mv.move_valid, fill_count, buffer_dtr);
        end
    endtask

    task automatic test_errors();
        send_word({8'h55, 56'd0});
        total++;
        if (header_err !== 1'b1) begin
            bad++;
            $display("FAIL header_err got=%b need=1", header_err);
        end
        send_word({8'h0C, 56'd0});
        total++;
        if (word_send_data !== {1'b1, 1'b1, 62'd0}) begin
            bad++;
            $display("FAIL status got=%h need=c000000000000000", word_send_data);
        end
        send_word({8'h55, 56'd0});          // drained
        send_word({8'h0D, 56'd0});
        exp_ovf = 1'b0;
        total++;
        if (header_err !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL clear got h=%b o=%b need 0/0", header_err, overflow_err);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++)
            send_move(2'b01, 64'(200 + i), 64'(7), 64'(8), 64'(9), 64'(i), 1'b0);
        send_move(2'b11, 64'd300, 64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
        total++;
        if (fill_count !== 3'd4 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL coincide got fill=%0d ovf=%b need 4/0", fill_count, overflow_err);
        end
        for (int i = 0; i < 4; i++) pop_one("coin_pop");
    endtask

    task automatic test_reset_mid_message();
        send_move(2'b01, 64'd55, 64'd1, 64'd1, 64'd1, 64'd1, 1'b0);
        send_word({8'h01, 54'd0, 2'b01});
        send_word(64'd77);
        send_word(64'd3);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        sb.delete();
        total++;
        if (mv.move_valid !== 1'b0 || fill_count !== 3'd0 || word_send_data !== 64'd0) begin
            bad++;
            $display("FAIL mid_reset got v=%b fill=%0d ws=%h need 0/0/0", mv.move_valid, fill_count, word_send_data);
        end
        send_word({8'h0A, 54'd0, 2'b11});
        total++;
        if (enable !== 2'b11 || mv.move_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_after_reset got en=%b v=%b need 11/0", enable, mv.move_valid);
        end
    endtask

    initial begin
        reset         = 1'b1;
        word_valid    = 1'b0;
        word_data     = '0;
        mv.move_ready = 1'b0;
        encoder_count = {ENC1, ENC0};
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_version();
        test_single_move();
        test_overflow();
        test_errors();
        test_full_push_pop();
        test_reset_mid_message();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_move_dispatcher.md
# spi_move_dispatcher

Parametrised command dispatcher for a multi-axis motion controller. It receives already-deframed 64-bit SPI words, decodes headers, and assembles coordinated multi-axis moves in a staging register. Complete moves are committed into a BUFFER_DEPTH-entry FIFO that feeds the DDA timer over a valid/ready handshake. It also holds enable/divisor config, snapshots encoder counts for readback, and reports overflow and protocol errors.

## Interface
- NUM_AXES, 2, axes per coordinated move (1..8)
- BUFFER_DEPTH, 4, move FIFO entries; power of two, ≥2
- VERSION, 24'h000100, {major,minor,patch} returned by API version query
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- word_valid  in  1  one-cycle pulse: word_data holds a new received word
- word_data  in  64  received word, little-endian; header in [63:56]
- word_send_data  out  64  word shifted out during the next SPI word
- encoder_count  in  64*NUM_AXES  live encoder counts, axis k at [64k+63:64k]
- move_valid  out  1  FIFO head valid
- move_ready  in  1  DDA accepts head
- move_duration  out  64  head duration
- move_increment  out  64*NUM_AXES  head per-axis increment (signed)
- move_incrementincrement  out  64*NUM_AXES  head per-axis increment delta (signed)
- move_dir  out  NUM_AXES  head direction bits
- enable  out  NUM_AXES  per-axis driver enable
- clock_divisor  out  8  DDA tick divisor
- buffer_dtr  out  1  FIFO not full
- fill_count  out  clog2(BUFFER_DEPTH)+1  entries held
- overflow_err  out  1  sticky: a move was dropped on a full FIFO
- header_err  out  1  sticky: unknown header received

## Operation
- Headers: 0x01 COORDINATED_STEP, 0x0A MOTOR_ENABLE, 0x0B CLK_DIVISOR, 0x0C STATUS, 0x0D CLEAR_ERRORS, 0xFE API_VERSION.
- States: IDLE, DURATION, INC(k), INCINC(k), DRAIN. State and axis index k advance only on word_valid.
- IDLE: word_send_data <= 0 on every accepted word unless set below.
  - 0x01: latch dir_stage <= word_data[NUM_AXES-1:0]; snapshot all encoder_count; word_send_data <= encoder axis 0; -> DURATION.
  - 0x0A: enable <= word_data[NUM_AXES-1:0]. 0x0B: clock_divisor <= word_data[7:0]. 0x0D: clear both sticky flags. All stay IDLE.
  - 0x0C: word_send_data <= {overflow_err, header_err, zero-extended fill_count in [15:0]}; -> DRAIN.
  - 0xFE: word_send_data[23:0] <= VERSION; -> DRAIN.
  - other: header_err <= 1; stay IDLE.
- DURATION: dur_stage <= word_data; word_send_data <= snapshot axis 1 (0 if NUM_AXES=1); -> INC(0).
- INC(k): inc_stage[k] <= word_data; -> INCINC(k).
- INCINC(k): incinc_stage[k] <= word_data; if k<NUM_AXES-1 -> INC(k+1) with word_send_data <= snapshot axis k+2 (0 if none); else commit, -> IDLE.
- Message length 2+2*NUM_AXES words; axis n's snapshot (n≥2) is sent after INCINC(n-2).
- Commit: push {dir, dur, inc, incinc} if FIFO not full, or full with a pop in the same cycle. Otherwise drop and set overflow_err <= 1. A move is never partially written.
- DRAIN: any word is consumed and ignored, header not decoded; -> IDLE.
- FIFO: first-word fall-through; head fields valid while move_valid; pop when move_valid && move_ready. Pointers wrap modulo BUFFER_DEPTH; fill_count is an explicit counter, so full (=BUFFER_DEPTH) and empty (=0) are distinct.
- Simultaneous push and pop leaves fill_count unchanged. Set and clear of a sticky flag in the same cycle: set wins.

## Timing
- Reset values: state IDLE, k=0, FIFO empty, move_valid 0, fill_count 0, buffer_dtr 1, enable 0, clock_divisor 40, word_send_data 0, both error flags 0. Head data outputs are don't-care while move_valid=0.
- Reset mid-message discards staging; no partial commit.
- Every register update lands one cycle after the word_valid cycle (latency 1).
- move_valid rises the cycle after a commit into an empty FIFO.
- buffer_dtr and fill_count are registered and reflect push/pop one cycle later.
- word_valid pulses are at least 2 cycles apart (SPI framing guarantees this); no back-pressure on the word side.

## Test plan
- Reset, then send 0xFE header -> next cycle word_send_data = 0x000100; the next word is drained; state returns to IDLE.
- NUM_AXES=2: send header 0x01 with dir=2'b10, duration 1000, inc {5, -3}, incinc {1, 0} -> move_valid=1, move_dir=2'b10, move_duration=1000, move_increment axis1=-3. Encoder snapshots appear on word_send_data after the header and after the duration word.
- Hold move_ready=0 and send 5 moves with DEPTH=4 -> fill_count=4, buffer_dtr=0, fifth move dropped, overflow_err=1. Pop all four -> the four original durations come out in order.
- With FIFO full, make the commit word coincide with move_ready=1 -> push succeeds, fill_count stays 4, overflow_err stays 0.
- Send header 0x55 -> header_err=1. Send 0x0C -> status word shows bit 62 set. Send 0x0D -> both flags 0.
- Assert reset after 3 words of a move -> FIFO empty, IDLE. Then send 0x0A with 2'b11 -> enable=2'b11, decoded as a header.
